// File: rtl/bomb_display_ctrl.sv
// Bomb display controller: registers the timer digits, drives four active-low
// 7-segment displays and runs a warning beeper / explosion blink FSM.
module bomb_display_ctrl #(
  parameter int BLINK_HALF   = 250,
  parameter int WARN_SECONDS = 10,
  parameter int BEEP_LEN     = 50
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       TICK,
  input  logic [0:3] DECIMOS,
  input  logic [0:3] SEG_UNI,
  input  logic [0:3] SEG_DEC,
  input  logic [0:3] MINUTOS,
  input  logic       TEMPO_ACABOU,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic       DP_N,
  output logic       BUZZER,
  output logic [1:0] STATE
);

  localparam int BLINK_W = $clog2(BLINK_HALF + 1);
  localparam int BEEP_W  = $clog2(BEEP_LEN + 1);

  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_WARNING  = 2'd1,
    ST_EXPLODED = 2'd2,
    ST_UNUSED   = 2'd3
  } state_t;

  state_t             state_r;
  logic [3:0]         decimos_r;
  logic [3:0]         seg_uni_r;
  logic [3:0]         seg_uni_prev_r;
  logic [3:0]         seg_dec_r;
  logic [3:0]         minutos_r;
  logic               tempo_r;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic               phase_r;
  logic [BEEP_W-1:0]  beep_cnt_r;

  logic [7:0]         secs_s;
  logic               warn_s;
  logic               warn_next_s;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  assign secs_s = ({4'd0, seg_dec_r} * 8'd10) + {4'd0, seg_uni_r};
  assign warn_s = (minutos_r == 4'd0) && (secs_s < 8'(WARN_SECONDS));
  // True when the FSM will be in WARNING after this edge, so a digit change
  // on the entry edge still starts a chirp.
  assign warn_next_s = ((state_r == ST_NORMAL) || (state_r == ST_WARNING)) &&
                       !tempo_r && warn_s;
  assign STATE = state_r;

  // Input capture, independent of TICK.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      decimos_r      <= 4'd0;
      seg_uni_r      <= 4'd0;
      seg_uni_prev_r <= 4'd0;
      seg_dec_r      <= 4'd0;
      minutos_r      <= 4'd0;
      tempo_r        <= 1'b0;
    end else begin
      decimos_r      <= DECIMOS;
      seg_uni_r      <= SEG_UNI;
      seg_uni_prev_r <= seg_uni_r;
      seg_dec_r      <= SEG_DEC;
      minutos_r      <= MINUTOS;
      tempo_r        <= TEMPO_ACABOU;
    end
  end

  // FSM, blink/beep counters and registered display/buzzer outputs.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_r     <= ST_NORMAL;
      blink_cnt_r <= '0;
      phase_r     <= 1'b0;
      beep_cnt_r  <= '0;
      HEX0        <= SEG_ZERO;
      HEX1        <= SEG_ZERO;
      HEX2        <= SEG_ZERO;
      HEX3        <= SEG_ZERO;
      DP_N        <= 1'b0;
      BUZZER      <= 1'b0;
    end else begin
      case (state_r)
        ST_NORMAL: begin
          if (tempo_r)     state_r <= ST_EXPLODED;
          else if (warn_s) state_r <= ST_WARNING;
          else             state_r <= ST_NORMAL;
        end
        ST_WARNING: begin
          if (tempo_r)      state_r <= ST_EXPLODED;
          else if (!warn_s) state_r <= ST_NORMAL;
          else              state_r <= ST_WARNING;
        end
        ST_EXPLODED: begin
          if (!tempo_r) state_r <= ST_NORMAL;
          else          state_r <= ST_EXPLODED;
        end
        default: state_r <= ST_NORMAL;
      endcase

      if (state_r != ST_EXPLODED) begin
        blink_cnt_r <= '0;
        phase_r     <= 1'b0;
      end else if (TICK) begin
        if (blink_cnt_r == BLINK_W'(BLINK_HALF - 1)) begin
          blink_cnt_r <= '0;
          phase_r     <= ~phase_r;
        end else begin
          blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
        end
      end else begin
        blink_cnt_r <= blink_cnt_r;
      end

      // A fresh seconds digit reloads the chirp even mid-decrement.
      if (!warn_next_s) begin
        beep_cnt_r <= '0;
      end else if (seg_uni_r != seg_uni_prev_r) begin
        beep_cnt_r <= BEEP_W'(BEEP_LEN);
      end else if (TICK && (beep_cnt_r != '0)) begin
        beep_cnt_r <= beep_cnt_r - BEEP_W'(1);
      end else begin
        beep_cnt_r <= beep_cnt_r;
      end

      case (state_r)
        ST_EXPLODED: begin
          HEX0   <= phase_r ? SEG_OFF : SEG_ZERO;
          HEX1   <= phase_r ? SEG_OFF : SEG_ZERO;
          HEX2   <= phase_r ? SEG_OFF : SEG_ZERO;
          HEX3   <= phase_r ? SEG_OFF : SEG_ZERO;
          DP_N   <= phase_r;
          BUZZER <= 1'b1;
        end
        ST_WARNING: begin
          HEX0   <= seg_decode(decimos_r);
          HEX1   <= seg_decode(seg_uni_r);
          HEX2   <= seg_decode(seg_dec_r);
          HEX3   <= seg_decode(minutos_r);
          DP_N   <= 1'b0;
          BUZZER <= (beep_cnt_r != '0);
        end
        default: begin
          HEX0   <= seg_decode(decimos_r);
          HEX1   <= seg_decode(seg_uni_r);
          HEX2   <= seg_decode(seg_dec_r);
          HEX3   <= seg_decode(minutos_r);
          DP_N   <= 1'b0;
          BUZZER <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bomb_display_ctrl.sv
// Directed testbench for bomb_display_ctrl: decode, warning chirp,
// explosion blink, recovery and reset abort.
module tb_bomb_display_ctrl;

  localparam int BH = 250;
  localparam int BL = 50;

  localparam logic [6:0] P0    = 7'b1000000;
  localparam logic [6:0] P1    = 7'b1111001;
  localparam logic [6:0] P2    = 7'b0100100;
  localparam logic [6:0] P3    = 7'b0110000;
  localparam logic [6:0] P4    = 7'b0011001;
  localparam logic [6:0] P5    = 7'b0010010;
  localparam logic [6:0] P6    = 7'b0000010;
  localparam logic [6:0] P7    = 7'b1111000;
  localparam logic [6:0] P8    = 7'b0000000;
  localparam logic [6:0] P9    = 7'b0010000;
  localparam logic [6:0] PDASH = 7'b0111111;
  localparam logic [6:0] POFF  = 7'b1111111;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic       TICK;
  logic [3:0] DECIMOS, SEG_UNI, SEG_DEC, MINUTOS;
  logic       TEMPO_ACABOU;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  logic       DP_N, BUZZER;
  logic [1:0] STATE;

  int tests = 0;
  int fails = 0;

  bomb_display_ctrl #(.BLINK_HALF(BH), .WARN_SECONDS(10), .BEEP_LEN(BL)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .TICK(TICK),
    .DECIMOS(DECIMOS), .SEG_UNI(SEG_UNI), .SEG_DEC(SEG_DEC), .MINUTOS(MINUTOS),
    .TEMPO_ACABOU(TEMPO_ACABOU),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .DP_N(DP_N), .BUZZER(BUZZER), .STATE(STATE)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      TICK = 1'b1;
      cyc(1);
    end
    TICK = 1'b0;
  endtask

  task automatic set_digits(input logic [3:0] m, input logic [3:0] sd,
                            input logic [3:0] su, input logic [3:0] d);
    MINUTOS = m; SEG_DEC = sd; SEG_UNI = su; DECIMOS = d;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_hex(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                           input logic [6:0] e1, input logic [6:0] e0);
    check({tag, ".hex3"}, {1'b0, HEX3}, {1'b0, e3});
    check({tag, ".hex2"}, {1'b0, HEX2}, {1'b0, e2});
    check({tag, ".hex1"}, {1'b0, HEX1}, {1'b0, e1});
    check({tag, ".hex0"}, {1'b0, HEX0}, {1'b0, e0});
  endtask

  initial begin
    RESET = 1'b1; TICK = 1'b0; TEMPO_ACABOU = 1'b0;
    set_digits(4'd2, 4'd0, 4'd0, 4'd0);

    // 1. reset state, then 2:00.0 shown
    cyc(2);
    check_hex("rst", P0, P0, P0, P0);
    check("rst.dp", {7'd0, DP_N}, 8'd0);
    check("rst.buz", {7'd0, BUZZER}, 8'd0);
    check("rst.state", {6'd0, STATE}, 8'd0);
    RESET = 1'b0;
    cyc(3);
    check_hex("t1", P2, P0, P0, P0);
    check("t1.buz", {7'd0, BUZZER}, 8'd0);
    check("t1.state", {6'd0, STATE}, 8'd0);

    // 2. countdown into the warning window
    set_digits(4'd0, 4'd1, 4'd1, 4'd0);
    cyc(3);
    check("t2.11.state", {6'd0, STATE}, 8'd0);
    set_digits(4'd0, 4'd1, 4'd0, 4'd9);
    cyc(3);
    check("t2.10.state", {6'd0, STATE}, 8'd0);
    check("t2.10.buz", {7'd0, BUZZER}, 8'd0);
    set_digits(4'd0, 4'd0, 4'd9, 4'd9);
    cyc(1);
    check("t2.09.state_early", {6'd0, STATE}, 8'd0);
    cyc(1);
    check("t2.09.state", {6'd0, STATE}, 8'd1);
    cyc(1);
    check("t2.beep.start", {7'd0, BUZZER}, 8'd1);
    check_hex("t2", P0, P0, P9, P9);
    cyc(5);
    check("t2.beep.hold", {7'd0, BUZZER}, 8'd1);
    tick_n(BL - 1);
    cyc(1);
    check("t2.beep.49", {7'd0, BUZZER}, 8'd1);
    tick_n(1);
    cyc(1);
    check("t2.beep.50", {7'd0, BUZZER}, 8'd0);
    check("t2.state.hold", {6'd0, STATE}, 8'd1);

    // 3. explosion blink, three full periods
    TEMPO_ACABOU = 1'b1;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    cyc(3);
    check("t3.state", {6'd0, STATE}, 8'd2);
    check("t3.buz", {7'd0, BUZZER}, 8'd1);
    check_hex("t3.entry", P0, P0, P0, P0);
    for (int p = 0; p < 3; p++) begin
      tick_n(BH - 1);
      cyc(1);
      check_hex("t3.on", P0, P0, P0, P0);
      check("t3.on.dp", {7'd0, DP_N}, 8'd0);
      tick_n(1);
      cyc(1);
      check_hex("t3.off", POFF, POFF, POFF, POFF);
      check("t3.off.dp", {7'd0, DP_N}, 8'd1);
      check("t3.off.buz", {7'd0, BUZZER}, 8'd1);
      tick_n(BH - 1);
      cyc(1);
      check("t3.off.hold", {1'b0, HEX0}, {1'b0, POFF});
      tick_n(1);
      cyc(1);
      check("t3.back_on", {1'b0, HEX0}, {1'b0, P0});
    end
    tick_n(100);

    // 4. timer restarted from mid-count
    TEMPO_ACABOU = 1'b0;
    set_digits(4'd2, 4'd0, 4'd0, 4'd0);
    cyc(2);
    check("t4.state", {6'd0, STATE}, 8'd0);
    cyc(1);
    check("t4.buz", {7'd0, BUZZER}, 8'd0);
    check("t4.dp", {7'd0, DP_N}, 8'd0);
    check_hex("t4", P2, P0, P0, P0);

    // 5. decode coverage and dash for invalid codes
    set_digits(4'd1, 4'd8, 4'd7, 4'd5);
    cyc(2);
    check_hex("t5.a", P1, P8, P7, P5);
    set_digits(4'd9, 4'd4, 4'd6, 4'd3);
    cyc(2);
    check_hex("t5.b", P9, P4, P6, P3);
    set_digits(4'hF, 4'd6, 4'hA, 4'hC);
    cyc(2);
    check_hex("t5.dash", PDASH, P6, PDASH, PDASH);
    set_digits(4'd2, 4'd0, 4'd0, 4'd3);
    cyc(2);
    check_hex("t5.restore", P2, P0, P0, P3);

    // 6a. re-entered explosion starts from a cleared blink counter; reset mid-blink
    TEMPO_ACABOU = 1'b1;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    cyc(3);
    tick_n(BH - 1);
    cyc(1);
    check("t6.blink_cleared", {1'b0, HEX0}, {1'b0, P0});
    tick_n(1);
    cyc(1);
    check("t6.phase1", {1'b0, HEX3}, {1'b0, POFF});
    RESET = 1'b1;
    cyc(1);
    check("t6.blink_rst.buz", {7'd0, BUZZER}, 8'd0);
    check("t6.blink_rst.state", {6'd0, STATE}, 8'd0);
    check_hex("t6.blink_rst", P0, P0, P0, P0);
    TEMPO_ACABOU = 1'b0;
    set_digits(4'd2, 4'd0, 4'd0, 4'd0);
    RESET = 1'b0;
    cyc(4);
    check("t6.recover.state", {6'd0, STATE}, 8'd0);

    // 6b. reset mid-beep
    set_digits(4'd0, 4'd0, 4'd5, 4'd0);
    cyc(2);
    check("t6.warn.state", {6'd0, STATE}, 8'd1);
    tick_n(BL - 20);
    check("t6.beeping", {7'd0, BUZZER}, 8'd1);
    RESET = 1'b1;
    set_digits(4'd2, 4'd0, 4'd0, 4'd0);
    cyc(1);
    check("t6.beep_rst.buz", {7'd0, BUZZER}, 8'd0);
    check("t6.beep_rst.state", {6'd0, STATE}, 8'd0);
    check_hex("t6.beep_rst", P0, P0, P0, P0);
    RESET = 1'b0;
    cyc(4);
    check("t6.after.buz", {7'd0, BUZZER}, 8'd0);
    check("t6.after.state", {6'd0, STATE}, 8'd0);
    check_hex("t6.after", P2, P0, P0, P0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
